// File: rtl/svga_timing_gen_if.sv
// Raster timing bundle from svga_timing_gen to its consumers.
// master: driven by the timing generator; slave: pixel logic / VGA pins.
//   pixel_count, line_count : current raster position (11 b each)
//   h_synch, v_synch        : sync pulses at the configured polarity
//   blank                   : 1 outside the visible area
//   line_start, frame_start : one-cycle strobes at the start of a line / frame
interface svga_timing_gen_if;
    logic [10:0] pixel_count;
    logic [10:0] line_count;
    logic        h_synch;
    logic        v_synch;
    logic        blank;
    logic        line_start;
    logic        frame_start;

    modport master (
        output pixel_count,
        output line_count,
        output h_synch,
        output v_synch,
        output blank,
        output line_start,
        output frame_start
    );

    modport slave (
        input pixel_count,
        input line_count,
        input h_synch,
        input v_synch,
        input blank,
        input line_start,
        input frame_start
    );
endinterface

// File: rtl/svga_timing_gen.sv
// Raster timing generator: horizontal/vertical counters decoded into sync pulses,
// blanking, coordinates and line/frame strobes. Defaults give 640x480 @ 60 Hz.
//   pixel_clock : the only clock
//   reset_n     : asynchronous active-low reset
//   vga         : registered timing outputs (svga_timing_gen_if master)
// Every output is a flop fed from the decode of the same counter state, so all
// outputs are mutually aligned and lag the internal counters by one cycle.
module svga_timing_gen #(
    parameter int unsigned H_ACTIVE   = 640,
    parameter int unsigned H_FRONT    = 16,
    parameter int unsigned H_SYNC     = 96,
    parameter int unsigned H_BACK     = 48,
    parameter int unsigned V_ACTIVE   = 480,
    parameter int unsigned V_FRONT    = 10,
    parameter int unsigned V_SYNC     = 2,
    parameter int unsigned V_BACK     = 33,
    parameter bit          H_SYNC_POL = 1'b0,
    parameter bit          V_SYNC_POL = 1'b0
) (
    input  logic               pixel_clock,
    input  logic               reset_n,
    svga_timing_gen_if.master  vga
);

    localparam logic [10:0] H_MAX    = 11'(H_ACTIVE + H_FRONT + H_SYNC + H_BACK - 1);
    localparam logic [10:0] V_MAX    = 11'(V_ACTIVE + V_FRONT + V_SYNC + V_BACK - 1);
    localparam logic [10:0] H_VIS    = 11'(H_ACTIVE);
    localparam logic [10:0] V_VIS    = 11'(V_ACTIVE);
    localparam logic [10:0] HS_START = 11'(H_ACTIVE + H_FRONT);
    localparam logic [10:0] HS_END   = 11'(H_ACTIVE + H_FRONT + H_SYNC);
    localparam logic [10:0] VS_START = 11'(V_ACTIVE + V_FRONT);
    localparam logic [10:0] VS_END   = 11'(V_ACTIVE + V_FRONT + V_SYNC);

    logic [10:0] h_cnt, h_cnt_d;
    logic [10:0] v_cnt, v_cnt_d;
    logic        h_last, v_last;
    logic        h_synch_d, v_synch_d, blank_d, line_start_d, frame_start_d;

    always_comb begin
        h_last  = (h_cnt == H_MAX);
        v_last  = (v_cnt == V_MAX);
        h_cnt_d = h_last ? 11'd0 : h_cnt + 11'd1;
        v_cnt_d = v_cnt;
        if (h_last) begin
            v_cnt_d = v_last ? 11'd0 : v_cnt + 11'd1;
        end
    end

    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            h_cnt <= 11'd0;
            v_cnt <= 11'd0;
        end else begin
            h_cnt <= h_cnt_d;
            v_cnt <= v_cnt_d;
        end
    end

    // Decode of the current counters; vsync covers whole lines, not pixel-aligned.
    always_comb begin
        h_synch_d     = ((h_cnt >= HS_START) && (h_cnt < HS_END)) ? H_SYNC_POL : ~H_SYNC_POL;
        v_synch_d     = ((v_cnt >= VS_START) && (v_cnt < VS_END)) ? V_SYNC_POL : ~V_SYNC_POL;
        blank_d       = (h_cnt >= H_VIS) || (v_cnt >= V_VIS);
        line_start_d  = (h_cnt == 11'd0);
        frame_start_d = (h_cnt == 11'd0) && (v_cnt == 11'd0);
    end

    always_ff @(posedge pixel_clock or negedge reset_n) begin
        if (!reset_n) begin
            vga.pixel_count <= 11'd0;
            vga.line_count  <= 11'd0;
            vga.h_synch     <= ~H_SYNC_POL;
            vga.v_synch     <= ~V_SYNC_POL;
            vga.blank       <= 1'b1;
            vga.line_start  <= 1'b0;
            vga.frame_start <= 1'b0;
        end else begin
            vga.pixel_count <= h_cnt;
            vga.line_count  <= v_cnt;
            vga.h_synch     <= h_synch_d;
            vga.v_synch     <= v_synch_d;
            vga.blank       <= blank_d;
            vga.line_start  <= line_start_d;
            vga.frame_start <= frame_start_d;
        end
    end

endmodule

// File: tb/tb_svga_timing_gen.sv
// Bench for svga_timing_gen. Instance a uses the default 640x480 timing with
// active-low syncs; instance b uses a reduced raster (25 x 15, active-high syncs)
// so whole frames, the vertical window and frame wrap fit in a short run.
// b timing: H 16/2/3/4 (hsync pixels 18..20), V 8/2/2/3 (vsync lines 10..11).
module tb_svga_timing_gen;

    typedef struct {
        int cyc;   // edge index after reset release; -1 = value held during reset
        int p;
        int l;
        bit hs;
        bit vs;
        bit bl;
        bit ls;
        bit fs;
    } exp_t;

    logic clk = 1'b0;
    logic reset_n = 1'b1;

    svga_timing_gen_if vga_a ();
    svga_timing_gen_if vga_b ();

    svga_timing_gen u_a (
        .pixel_clock (clk),
        .reset_n     (reset_n),
        .vga         (vga_a)
    );

    svga_timing_gen #(
        .H_ACTIVE   (16),
        .H_FRONT    (2),
        .H_SYNC     (3),
        .H_BACK     (4),
        .V_ACTIVE   (8),
        .V_FRONT    (2),
        .V_SYNC     (2),
        .V_BACK     (3),
        .H_SYNC_POL (1'b1),
        .V_SYNC_POL (1'b1)
    ) u_b (
        .pixel_clock (clk),
        .reset_n     (reset_n),
        .vga         (vga_b)
    );

    always #20 clk = ~clk;

    exp_t qa[$];
    exp_t qb[$];
    int   cyc = -1;
    int   checks = 0;
    int   errors = 0;
    bit   drain = 1'b0;
    bit   timeout_flag = 1'b0;

    always @(posedge clk or negedge reset_n) begin
        if (!reset_n) cyc <= -1;
        else          cyc <= cyc + 1;
    end

    function automatic exp_t mk(int c, int p, int l, bit hs, bit vs, bit bl, bit ls, bit fs);
        exp_t e;
        e.cyc = c; e.p = p; e.l = l; e.hs = hs; e.vs = vs; e.bl = bl; e.ls = ls; e.fs = fs;
        return e;
    endfunction

    task automatic check(input string name, input int got, input int want);
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL %s got %0d expected %0d", name, got, want);
        end
    endtask

    task automatic cmp(input string tag, input exp_t e, input int p, input int l,
                       input bit hs, input bit vs, input bit bl, input bit ls, input bit fs);
        check($sformatf("%s_c%0d_pixel", tag, e.cyc), p, e.p);
        check($sformatf("%s_c%0d_line", tag, e.cyc), l, e.l);
        check($sformatf("%s_c%0d_hsync", tag, e.cyc), int'(hs), int'(e.hs));
        check($sformatf("%s_c%0d_vsync", tag, e.cyc), int'(vs), int'(e.vs));
        check($sformatf("%s_c%0d_blank", tag, e.cyc), int'(bl), int'(e.bl));
        check($sformatf("%s_c%0d_lstart", tag, e.cyc), int'(ls), int'(e.ls));
        check($sformatf("%s_c%0d_fstart", tag, e.cyc), int'(fs), int'(e.fs));
    endtask

    // Monitor: pops expected vectors when the DUT reaches their cycle, plus
    // continuous protocol checks on pulse widths and periods.
    int a_hs_run, a_last_ls;
    int b_hs_run, b_vs_run, b_last_fs, b_ls_cnt;
    bit b_vs_prev;

    initial begin : monitor
        exp_t e;
        bit   hs_on, vs_on;
        a_hs_run = 0; a_last_ls = -1;
        b_hs_run = 0; b_vs_run = 0; b_last_fs = -1; b_ls_cnt = 0; b_vs_prev = 1'b0;
        forever begin
            @(negedge clk or negedge reset_n);
            if (drain) begin
                check("a_leftover_vectors", qa.size(), 0);
                check("b_leftover_vectors", qb.size(), 0);
                check("stim_wait_timeout", int'(timeout_flag), 0);
                $display("CHECKS %0d ERRORS %0d", checks, errors);
                $finish;
            end
            if (!reset_n) begin
                #2;
                while (qa.size() > 0 && qa[0].cyc < 0) begin
                    e = qa.pop_front();
                    cmp("a_rst", e, int'(vga_a.pixel_count), int'(vga_a.line_count),
                        vga_a.h_synch, vga_a.v_synch, vga_a.blank, vga_a.line_start,
                        vga_a.frame_start);
                end
                while (qb.size() > 0 && qb[0].cyc < 0) begin
                    e = qb.pop_front();
                    cmp("b_rst", e, int'(vga_b.pixel_count), int'(vga_b.line_count),
                        vga_b.h_synch, vga_b.v_synch, vga_b.blank, vga_b.line_start,
                        vga_b.frame_start);
                end
                a_hs_run = 0; a_last_ls = -1;
                b_hs_run = 0; b_vs_run = 0; b_last_fs = -1; b_ls_cnt = 0; b_vs_prev = 1'b0;
            end else if (cyc >= 0) begin
                while (qa.size() > 0 && qa[0].cyc >= 0 && qa[0].cyc <= cyc) begin
                    e = qa.pop_front();
                    if (e.cyc < cyc) check("a_vector_missed", cyc, e.cyc);
                    else cmp("a", e, int'(vga_a.pixel_count), int'(vga_a.line_count),
                             vga_a.h_synch, vga_a.v_synch, vga_a.blank, vga_a.line_start,
                             vga_a.frame_start);
                end
                while (qb.size() > 0 && qb[0].cyc >= 0 && qb[0].cyc <= cyc) begin
                    e = qb.pop_front();
                    if (e.cyc < cyc) check("b_vector_missed", cyc, e.cyc);
                    else cmp("b", e, int'(vga_b.pixel_count), int'(vga_b.line_count),
                             vga_b.h_synch, vga_b.v_synch, vga_b.blank, vga_b.line_start,
                             vga_b.frame_start);
                end

                // Instance a: active-low hsync width, 800-cycle line period.
                hs_on = (vga_a.h_synch == 1'b0);
                if (hs_on) a_hs_run++;
                else if (a_hs_run > 0) begin
                    check("a_hsync_width", a_hs_run, 96);
                    a_hs_run = 0;
                end
                if (vga_a.line_start) begin
                    check("a_lstart_pixel0", int'(vga_a.pixel_count), 0);
                    if (a_last_ls >= 0) check("a_line_period", cyc - a_last_ls, 800);
                    a_last_ls = cyc;
                end

                // Instance b: frame period 375, 15 lines/frame, hsync 3, vsync 50.
                if (vga_b.frame_start) begin
                    if (b_last_fs >= 0) begin
                        check("b_frame_period", cyc - b_last_fs, 375);
                        check("b_lines_per_frame", b_ls_cnt, 15);
                    end
                    b_last_fs = cyc;
                    b_ls_cnt = 0;
                end
                if (vga_b.line_start) b_ls_cnt++;
                hs_on = (vga_b.h_synch == 1'b1);
                if (hs_on) b_hs_run++;
                else if (b_hs_run > 0) begin
                    check("b_hsync_width", b_hs_run, 3);
                    b_hs_run = 0;
                end
                vs_on = (vga_b.v_synch == 1'b1);
                if (vs_on != b_vs_prev) check("b_vsync_edge_pixel0", int'(vga_b.pixel_count), 0);
                if (vs_on) b_vs_run++;
                else if (b_vs_run > 0) begin
                    check("b_vsync_width", b_vs_run, 50);
                    b_vs_run = 0;
                end
                b_vs_prev = vs_on;
                if (vga_b.line_count >= 11'd8) check("b_blank_lower", int'(vga_b.blank), 1);
            end
        end
    end

    // Stimulus: queue hand-computed expectations, drive reset.
    initial begin : stim
        bit found;
        // Reset values.
        qa.push_back(mk(-1, 0, 0, 1, 1, 1, 0, 0));
        qb.push_back(mk(-1, 0, 0, 0, 0, 1, 0, 0));
        // Instance a: first edges, horizontal window, line wraps.
        qa.push_back(mk(0,    0,   0, 1, 1, 0, 1, 1));
        qa.push_back(mk(1,    1,   0, 1, 1, 0, 0, 0));
        qa.push_back(mk(639,  639, 0, 1, 1, 0, 0, 0));
        qa.push_back(mk(640,  640, 0, 1, 1, 1, 0, 0));
        qa.push_back(mk(655,  655, 0, 1, 1, 1, 0, 0));
        qa.push_back(mk(656,  656, 0, 0, 1, 1, 0, 0));
        qa.push_back(mk(751,  751, 0, 0, 1, 1, 0, 0));
        qa.push_back(mk(752,  752, 0, 1, 1, 1, 0, 0));
        qa.push_back(mk(799,  799, 0, 1, 1, 1, 0, 0));
        qa.push_back(mk(800,  0,   1, 1, 1, 0, 1, 0));
        qa.push_back(mk(1600, 0,   2, 1, 1, 0, 1, 0));
        // Instance b: hsync window, vertical window, frame wrap.
        qb.push_back(mk(0,   0,  0,  0, 0, 0, 1, 1));
        qb.push_back(mk(17,  17, 0,  0, 0, 1, 0, 0));
        qb.push_back(mk(18,  18, 0,  1, 0, 1, 0, 0));
        qb.push_back(mk(20,  20, 0,  1, 0, 1, 0, 0));
        qb.push_back(mk(21,  21, 0,  0, 0, 1, 0, 0));
        qb.push_back(mk(190, 15, 7,  0, 0, 0, 0, 0));
        qb.push_back(mk(191, 16, 7,  0, 0, 1, 0, 0));
        qb.push_back(mk(200, 0,  8,  0, 0, 1, 1, 0));
        qb.push_back(mk(249, 24, 9,  0, 0, 1, 0, 0));
        qb.push_back(mk(250, 0,  10, 0, 1, 1, 1, 0));
        qb.push_back(mk(299, 24, 11, 0, 1, 1, 0, 0));
        qb.push_back(mk(300, 0,  12, 0, 0, 1, 1, 0));
        qb.push_back(mk(374, 24, 14, 0, 0, 1, 0, 0));
        qb.push_back(mk(375, 0,  0,  0, 0, 0, 1, 1));
        qb.push_back(mk(750, 0,  0,  0, 0, 0, 1, 1));

        #5  reset_n = 1'b0;
        #125 reset_n = 1'b1;

        // Run until a reaches pixel 300, line 2, then reset between edges.
        found = 1'b0;
        for (int i = 0; i < 4000 && !found; i++) begin
            @(negedge clk);
            if (vga_a.pixel_count == 11'd300 && vga_a.line_count == 11'd2) found = 1'b1;
        end
        if (!found) timeout_flag = 1'b1;

        qa.push_back(mk(-1, 0, 0, 1, 1, 1, 0, 0));
        qb.push_back(mk(-1, 0, 0, 0, 0, 1, 0, 0));
        qa.push_back(mk(0,   0,   0, 1, 1, 0, 1, 1));
        qa.push_back(mk(1,   1,   0, 1, 1, 0, 0, 0));
        qa.push_back(mk(640, 640, 0, 1, 1, 1, 0, 0));
        qb.push_back(mk(0,   0,  0,  0, 0, 0, 1, 1));
        qb.push_back(mk(250, 0,  10, 0, 1, 1, 1, 0));
        qb.push_back(mk(375, 0,  0,  0, 0, 0, 1, 1));
        qb.push_back(mk(750, 0,  0,  0, 0, 0, 1, 1));

        #7 reset_n = 1'b0;
        repeat (3) @(negedge clk);
        #5 reset_n = 1'b1;

        repeat (800) @(negedge clk);
        drain = 1'b1;
        #1000;
        $display("FAIL monitor did not finish after drain");
        $fatal(1);
    end

    initial begin : watchdog
        #(40 * 20000);
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

endmodule

// File: doc/svga_timing_gen.md
# svga_timing_gen

Raster timing generator for the SVGA output path, clocked by `pixel_clock` from the clock divider (100 MHz system clock ÷ 4 = 25 MHz). It runs horizontal and vertical counters and decodes them into sync pulses, a blanking flag, the current pixel/line coordinates and frame/line start strobes. Downstream pixel-generation logic (counter display, character renderer) and the VGA pins consume these outputs. Default parameters give 640x480 @ 60 Hz.

## Interface
- `H_ACTIVE`, 640, visible pixels per line
- `H_FRONT`, 16, horizontal front porch (pixels)
- `H_SYNC`, 96, horizontal sync width (pixels)
- `H_BACK`, 48, horizontal back porch (pixels); H_TOTAL = sum = 800
- `V_ACTIVE`, 480, visible lines per frame
- `V_FRONT`, 10, vertical front porch (lines)
- `V_SYNC`, 2, vertical sync width (lines)
- `V_BACK`, 33, vertical back porch (lines); V_TOTAL = sum = 525
- `H_SYNC_POL`, 0, asserted level of `h_synch` (0 = active-low)
- `V_SYNC_POL`, 0, asserted level of `v_synch` (0 = active-low)
- `pixel_clock`  in  1  pixel clock; the only clock
- `reset_n`  in  1  asynchronous, active-low reset
- `pixel_count`  out  11  horizontal position, 0..H_TOTAL-1
- `line_count`  out  11  vertical position, 0..V_TOTAL-1
- `h_synch`  out  1  horizontal sync, polarity per H_SYNC_POL
- `v_synch`  out  1  vertical sync, polarity per V_SYNC_POL
- `blank`  out  1  1 outside the visible area
- `line_start`  out  1  one-cycle strobe at pixel_count = 0
- `frame_start`  out  1  one-cycle strobe at pixel_count = 0, line_count = 0

## Operation
- Internal counters `h_cnt` (11 b) and `v_cnt` (11 b), both 0 in reset.
- Each `pixel_clock`: `h_cnt` increments. At H_TOTAL-1 it wraps to 0 and `v_cnt` increments. When both are at maximum (799, 524) both wrap to 0 on the same edge.
- Counters never exceed H_TOTAL-1 / V_TOTAL-1. Width is fixed at 11 b, so parameter totals up to 2048 are supported.
- Decode, evaluated on the current `h_cnt`/`v_cnt`:
  - hsync asserted for H_ACTIVE+H_FRONT ≤ h_cnt < H_ACTIVE+H_FRONT+H_SYNC (656..751).
  - vsync asserted for V_ACTIVE+V_FRONT ≤ v_cnt < V_ACTIVE+V_FRONT+V_SYNC (490..491), for the whole line, not pixel-aligned.
  - blank = (h_cnt ≥ H_ACTIVE) | (v_cnt ≥ V_ACTIVE).
  - line_start = (h_cnt == 0).
  - frame_start = (h_cnt == 0) & (v_cnt == 0).
- All outputs are registered from the decode. `pixel_count`/`line_count` are the registered copies of `h_cnt`/`v_cnt`, so every output is mutually aligned.
- Sync level: output = POL when asserted, ~POL when deasserted.

## Timing
- Reset values while `reset_n` = 0 (asynchronous, immediate):
  - `pixel_count` = 0, `line_count` = 0
  - `h_synch` = ~H_SYNC_POL, `v_synch` = ~V_SYNC_POL
  - `blank` = 1
  - `line_start` = 0, `frame_start` = 0
- Latency: outputs lag internal counters by exactly one `pixel_clock`.
- First rising edge after `reset_n` deasserts: outputs show pixel 0, line 0, `blank` = 0, `line_start` = 1, `frame_start` = 1. The next edge shows pixel 1 with both strobes 0.
- Line period is H_TOTAL = 800 cycles. Frame period is H_TOTAL×V_TOTAL = 420000 cycles.
- `h_synch` is asserted for exactly H_SYNC = 96 consecutive cycles per line, including blanked lines.
- `v_synch` is asserted for exactly V_SYNC×H_TOTAL = 1600 cycles per frame. Its edges coincide with `pixel_count` = 0.
- Reset mid-frame: all outputs return to reset values asynchronously. The sequence restarts at pixel 0, line 0; no partial-frame state is retained.
- No glitches: all outputs come straight from flops.

## Test plan
- Reset hold, then release:
  - During reset, all outputs are at the listed reset values.
  - First edge after release: `pixel_count` = 0, `line_count` = 0, `frame_start` = `line_start` = 1, `blank` = 0.
- Horizontal window on line 0:
  - `blank` falls at pixel 0 and rises at pixel 640.
  - `h_synch` goes low at pixel 656 and high at pixel 752.
  - `pixel_count` wraps 799 → 0 and `line_count` goes 0 → 1 on the same edge, with `line_start` = 1.
- Vertical window:
  - `v_synch` is low only while `line_count` ∈ {490, 491}.
  - `blank` = 1 for all pixels of lines 480..524.
- Frame wrap:
  - At (799, 524), the next edge gives (0, 0) with `frame_start` = 1.
  - Exactly 420000 cycles separate consecutive `frame_start` pulses.
  - Exactly 525 `line_start` pulses occur per frame.
- Reset mid-operation:
  - Assert `reset_n` = 0 at pixel 300, line 200, asynchronously to the clock.
  - Outputs go to reset values before the next edge.
  - After release, the sequence restarts at (0, 0).
- Polarity parameters:
  - Run with H_SYNC_POL = 1, V_SYNC_POL = 1.
  - Reset gives `h_synch` = `v_synch` = 0.
  - Sync pulses are high over the same windows (656..751, lines 490..491).
